// File: rtl/reg_file_sb_if.sv
// Decode/writeback port bundle of the scoreboarded register file.
// Decode/writeback drives as master; the register file is the slave.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              regWr;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] RsAddr;
    logic [ADDR_W-1:0] RtAddr;
    logic              useRs;
    logic              useRt;
    logic              claimEn;
    logic [ADDR_W-1:0] claimAddr;
    logic [DATA_W-1:0] RsData;
    logic [DATA_W-1:0] RtData;
    logic              RsBusy;
    logic              RtBusy;
    logic              stall;

    modport master (
        output regWr, WriteAddr, WriteData,
        output RsAddr, RtAddr, useRs, useRt,
        output claimEn, claimAddr,
        input  RsData, RtData, RsBusy, RtBusy, stall
    );

    modport slave (
        input  regWr, WriteAddr, WriteData,
        input  RsAddr, RtAddr, useRs, useRt,
        input  claimEn, claimAddr,
        output RsData, RtData, RsBusy, RtBusy, stall
    );
endinterface

// File: rtl/reg_file_sb.sv
// 2R/1W register file with pending-write scoreboard, write bypass
// and optional hardwired r0; raises the decode stall on RAW / overflow.
module reg_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input logic          CLK,
    input logic          reset,
    reg_file_sb_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt  [DEPTH];

    logic             wrValid;
    logic             wdec;
    logic             cinc;
    logic             claimFull;
    logic             rsZero;
    logic             rtZero;
    logic             clZero;
    logic [CNT_W-1:0] rsEff;
    logic [CNT_W-1:0] rtEff;
    logic [CNT_W-1:0] clEff;
    logic [DEPTH-1:0] incVec;
    logic [DEPTH-1:0] decVec;

    always_comb begin
        wrValid = rf.regWr && !(ZERO_R0 && rf.WriteAddr == ZERO_A);
        wdec    = wrValid && (cnt[rf.WriteAddr] != '0);
        rsZero  = ZERO_R0 && rf.RsAddr == ZERO_A;
        rtZero  = ZERO_R0 && rf.RtAddr == ZERO_A;
        clZero  = ZERO_R0 && rf.claimAddr == ZERO_A;

        // a retiring writeback already counts as done when bypass is on
        rsEff = cnt[rf.RsAddr];
        rtEff = cnt[rf.RtAddr];
        clEff = cnt[rf.claimAddr];
        if (BYPASS && wdec && rf.WriteAddr == rf.RsAddr)
            rsEff = rsEff - CNT_ONE;
        if (BYPASS && wdec && rf.WriteAddr == rf.RtAddr)
            rtEff = rtEff - CNT_ONE;
        if (BYPASS && wdec && rf.WriteAddr == rf.claimAddr)
            clEff = clEff - CNT_ONE;

        rf.RsBusy = !rsZero && (rsEff != '0);
        rf.RtBusy = !rtZero && (rtEff != '0);
        claimFull = rf.claimEn && !clZero && (clEff == CNT_MAX);

        rf.stall = (rf.useRs && rf.RsBusy)
                 || (rf.useRt && rf.RtBusy)
                 || claimFull;
        cinc = rf.claimEn && !rf.stall && !clZero;

        if (rsZero)
            rf.RsData = '0;
        else if (BYPASS && rf.regWr && rf.WriteAddr == rf.RsAddr)
            rf.RsData = rf.WriteData;
        else
            rf.RsData = regs[rf.RsAddr];

        if (rtZero)
            rf.RtData = '0;
        else if (BYPASS && rf.regWr && rf.WriteAddr == rf.RtAddr)
            rf.RtData = rf.WriteData;
        else
            rf.RtData = regs[rf.RtAddr];

        incVec = '0;
        decVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            incVec[i] = cinc && rf.claimAddr == ADDR_W'(i);
            decVec[i] = wdec && rf.WriteAddr == ADDR_W'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (wrValid)
                regs[rf.WriteAddr] <= rf.WriteData;
            // claim and retire on the same register cancel out
            for (int i = 0; i < DEPTH; i++) begin
                unique case (1'b1)
                    incVec[i] && !decVec[i]: cnt[i] <= cnt[i] + CNT_ONE;
                    decVec[i] && !incVec[i]: cnt[i] <= cnt[i] - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one
// non-bypassing instance fed the same decode/writeback stimulus.
module tb_reg_file_sb;
    logic CLK;
    logic reset;
    int   total;
    int   bad;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) b ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) nb ();

    assign nb.regWr     = b.regWr;
    assign nb.WriteAddr = b.WriteAddr;
    assign nb.WriteData = b.WriteData;
    assign nb.RsAddr    = b.RsAddr;
    assign nb.RtAddr    = b.RtAddr;
    assign nb.useRs     = b.useRs;
    assign nb.useRt     = b.useRt;
    assign nb.claimEn   = b.claimEn;
    assign nb.claimAddr = b.claimAddr;

    reg_file_sb #(.BYPASS(1'b1)) dutB (
        .CLK  (CLK),
        .reset(reset),
        .rf   (b)
    );

    reg_file_sb #(.BYPASS(1'b0)) dutN (
        .CLK  (CLK),
        .reset(reset),
        .rf   (nb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        b.regWr     = 1'b0;
        b.WriteAddr = '0;
        b.WriteData = '0;
        b.RsAddr    = '0;
        b.RtAddr    = '0;
        b.useRs     = 1'b0;
        b.useRt     = 1'b0;
        b.claimEn   = 1'b0;
        b.claimAddr = '0;
    endtask

    // commit the current inputs, then settle just after the edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic claim(input logic [4:0] a);
        idle();
        b.claimEn   = 1'b1;
        b.claimAddr = a;
        cyc();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        b.regWr     = 1'b1;
        b.WriteAddr = a;
        b.WriteData = d;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        reset = 1'b1;
        for (int r = 1; r < 32; r++) begin
            b.RsAddr = 5'(r);
            b.RtAddr = 5'(r);
            b.useRs  = 1'b1;
            b.useRt  = 1'b1;
            #1;
            total++;
            if ({b.RsData, b.RtData, b.RsBusy, b.RtBusy, b.stall} !== 67'd0) begin
                bad++;
                $display("FAIL reset_b r%0d got=%h/%h %b%b%b want=0",
                         r, b.RsData, b.RtData, b.RsBusy, b.RtBusy, b.stall);
            end
            total++;
            if ({nb.RsData, nb.RtData, nb.RsBusy, nb.RtBusy, nb.stall} !== 67'd0) begin
                bad++;
                $display("FAIL reset_n r%0d got=%h/%h %b%b%b want=0",
                         r, nb.RsData, nb.RtData, nb.RsBusy, nb.RtBusy, nb.stall);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_raw_stall();
        idle();
        b.claimEn   = 1'b1;
        b.claimAddr = 5'd5;
        #1;
        total++;
        if (b.stall !== 1'b0) begin
            bad++;
            $display("FAIL raw_claim_stall got=%b want=0", b.stall);
        end
        cyc();
        for (int c = 1; c < 3; c++) begin
            idle();
            b.useRs  = 1'b1;
            b.RsAddr = 5'd5;
            #1;
            total++;
            if ({b.RsBusy, b.stall, nb.RsBusy, nb.stall} !== 4'b1111) begin
                bad++;
                $display("FAIL raw_busy c%0d got=%b%b%b%b want=1111",
                         c, b.RsBusy, b.stall, nb.RsBusy, nb.stall);
            end
            cyc();
        end
        b.regWr     = 1'b1;
        b.WriteAddr = 5'd5;
        b.WriteData = 32'hDEADBEEF;
        #1;
        total++;
        if ({b.RsBusy, b.stall, b.RsData} !== {2'b00, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL raw_bypass got=%b%b %h want=00 deadbeef",
                     b.RsBusy, b.stall, b.RsData);
        end
        total++;
        if ({nb.RsBusy, nb.stall, nb.RsData} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL raw_nobypass_wb got=%b%b %h want=11 0",
                     nb.RsBusy, nb.stall, nb.RsData);
        end
        cyc();
        b.regWr = 1'b0;
        #1;
        total++;
        if ({nb.RsBusy, nb.stall, nb.RsData} !== {2'b00, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL raw_nobypass_next got=%b%b %h want=00 deadbeef",
                     nb.RsBusy, nb.stall, nb.RsData);
        end
        total++;
        if ({b.RsBusy, b.stall, b.RsData} !== {2'b00, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL raw_bypass_next got=%b%b %h want=00 deadbeef",
                     b.RsBusy, b.stall, b.RsData);
        end
        idle();
        cyc();
    endtask

    task automatic test_zero_reg();
        idle();
        b.regWr     = 1'b1;
        b.WriteAddr = 5'd0;
        b.WriteData = 32'h1234;
        b.claimEn   = 1'b1;
        b.claimAddr = 5'd0;
        b.useRs     = 1'b1;
        b.useRt     = 1'b1;
        #1;
        total++;
        if ({b.RsData, b.RtData, b.RsBusy, b.stall} !== 66'd0) begin
            bad++;
            $display("FAIL zero_same got=%h %h %b%b want=0",
                     b.RsData, b.RtData, b.RsBusy, b.stall);
        end
        cyc();
        idle();
        b.useRs = 1'b1;
        b.useRt = 1'b1;
        #1;
        total++;
        if ({b.RsData, nb.RtData, b.RsBusy, nb.RtBusy, b.stall, nb.stall} !== 68'd0) begin
            bad++;
            $display("FAIL zero_after got=%h %h %b%b%b%b want=0",
                     b.RsData, nb.RtData, b.RsBusy, nb.RtBusy, b.stall, nb.stall);
        end
        cyc();
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            idle();
            b.claimEn   = 1'b1;
            b.claimAddr = 5'd7;
            b.RtAddr    = 5'd7;
            #1;
            total++;
            if ({b.stall, nb.stall, b.RtBusy} !== {2'b00, k != 0}) begin
                bad++;
                $display("FAIL full_claim k%0d got=%b%b%b want=00%b",
                         k, b.stall, nb.stall, b.RtBusy, k != 0);
            end
            cyc();
        end
        b.claimEn = 1'b1;
        #1;
        total++;
        if ({b.stall, nb.stall} !== 2'b11) begin
            bad++;
            $display("FAIL full_fourth got=%b%b want=11", b.stall, nb.stall);
        end
        cyc();
        for (int k = 1; k <= 3; k++) begin
            idle();
            b.regWr     = 1'b1;
            b.WriteAddr = 5'd7;
            b.WriteData = 32'(k);
            b.RtAddr    = 5'd7;
            #1;
            total++;
            if ({b.RtBusy, nb.RtBusy} !== {k != 3, 1'b1}) begin
                bad++;
                $display("FAIL full_wb k%0d got=%b%b want=%b1",
                         k, b.RtBusy, nb.RtBusy, k != 3);
            end
            cyc();
        end
        idle();
        b.RtAddr = 5'd7;
        b.useRt  = 1'b1;
        #1;
        total++;
        if ({b.RtBusy, nb.RtBusy, nb.stall, nb.RtData} !== {3'b000, 32'd3}) begin
            bad++;
            $display("FAIL full_drained got=%b%b%b %h want=000 3",
                     b.RtBusy, nb.RtBusy, nb.stall, nb.RtData);
        end
        cyc();
    endtask

    task automatic test_claim_write_same();
        claim(5'd9);
        idle();
        b.claimEn   = 1'b1;
        b.claimAddr = 5'd9;
        b.regWr     = 1'b1;
        b.WriteAddr = 5'd9;
        b.WriteData = 32'h99;
        b.RsAddr    = 5'd9;
        #1;
        total++;
        if ({b.RsBusy, b.stall, nb.RsBusy, nb.stall} !== 4'b0010) begin
            bad++;
            $display("FAIL same_cycle got=%b%b%b%b want=0010",
                     b.RsBusy, b.stall, nb.RsBusy, nb.stall);
        end
        cyc();
        idle();
        b.RsAddr = 5'd9;
        #1;
        total++;
        if ({b.RsBusy, nb.RsBusy, b.RsData} !== {2'b11, 32'h99}) begin
            bad++;
            $display("FAIL same_after got=%b%b %h want=11 99",
                     b.RsBusy, nb.RsBusy, b.RsData);
        end
        wr(5'd9, 32'hAA);
        b.RsAddr = 5'd9;
        #1;
        total++;
        if ({b.RsBusy, nb.RsBusy, nb.RsData} !== {2'b00, 32'hAA}) begin
            bad++;
            $display("FAIL same_retired got=%b%b %h want=00 aa",
                     b.RsBusy, nb.RsBusy, nb.RsData);
        end
        wr(5'd10, 32'h55);
        b.RsAddr = 5'd10;
        #1;
        total++;
        if ({b.RsBusy, nb.RsBusy, nb.RsData} !== {2'b00, 32'h55}) begin
            bad++;
            $display("FAIL unclaimed got=%b%b %h want=00 55",
                     b.RsBusy, nb.RsBusy, nb.RsData);
        end
        claim(5'd10);
        b.RsAddr = 5'd10;
        #1;
        total++;
        if ({b.RsBusy, nb.RsBusy} !== 2'b11) begin
            bad++;
            $display("FAIL unclaimed_then_claim got=%b%b want=11",
                     b.RsBusy, nb.RsBusy);
        end
        wr(5'd10, 32'h56);
        idle();
        cyc();
    endtask

    task automatic test_back_to_back();
        claim(5'd12);
        idle();
        b.claimEn   = 1'b1;
        b.claimAddr = 5'd13;
        b.regWr     = 1'b1;
        b.WriteAddr = 5'd12;
        b.WriteData = 32'hC0FFEE;
        b.RsAddr    = 5'd12;
        b.RtAddr    = 5'd13;
        #1;
        total++;
        if ({b.RsBusy, b.RtBusy, b.stall, b.RsData} !== {3'b000, 32'hC0FFEE}) begin
            bad++;
            $display("FAIL b2b_same got=%b%b%b %h want=000 c0ffee",
                     b.RsBusy, b.RtBusy, b.stall, b.RsData);
        end
        cyc();
        idle();
        b.RsAddr = 5'd12;
        b.RtAddr = 5'd13;
        #1;
        total++;
        if ({b.RsBusy, b.RtBusy, nb.RsBusy, nb.RtBusy} !== 4'b0101) begin
            bad++;
            $display("FAIL b2b_after got=%b%b%b%b want=0101",
                     b.RsBusy, b.RtBusy, nb.RsBusy, nb.RtBusy);
        end
        wr(5'd13, 32'h13);
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        wr(5'd3, 32'd7);
        claim(5'd3);
        claim(5'd3);
        idle();
        b.RsAddr = 5'd3;
        #1;
        total++;
        if ({b.RsBusy, nb.RsData} !== {1'b1, 32'd7}) begin
            bad++;
            $display("FAIL mid_before got=%b %h want=1 7", b.RsBusy, nb.RsData);
        end
        reset       = 1'b0;
        b.regWr     = 1'b1;
        b.WriteAddr = 5'd4;
        b.WriteData = 32'h44;
        b.claimEn   = 1'b1;
        b.claimAddr = 5'd4;
        cyc();
        reset = 1'b1;
        idle();
        b.RsAddr = 5'd3;
        b.RtAddr = 5'd4;
        b.useRs  = 1'b1;
        b.useRt  = 1'b1;
        #1;
        total++;
        if ({b.RsData, b.RtData, b.RsBusy, b.RtBusy, b.stall} !== 67'd0) begin
            bad++;
            $display("FAIL mid_cleared got=%h %h %b%b%b want=0",
                     b.RsData, b.RtData, b.RsBusy, b.RtBusy, b.stall);
        end
        b.regWr     = 1'b1;
        b.WriteAddr = 5'd3;
        b.WriteData = 32'd9;
        #1;
        total++;
        if ({b.RsData, b.RsBusy, nb.RsData, nb.stall} !== {32'd9, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_wb got=%h %b %h %b want=9 0 0 0",
                     b.RsData, b.RsBusy, nb.RsData, nb.stall);
        end
        cyc();
        idle();
        b.RsAddr = 5'd3;
        b.useRs  = 1'b1;
        #1;
        total++;
        if ({nb.RsData, nb.RsBusy, b.RsBusy, b.stall} !== {32'd9, 3'b000}) begin
            bad++;
            $display("FAIL mid_after got=%h %b%b%b want=9 000",
                     nb.RsData, nb.RsBusy, b.RsBusy, b.stall);
        end
        cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle();
        test_reset();
        test_raw_stall();
        test_zero_reg();
        test_full();
        test_claim_write_same();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised two-read/one-write register file with a per-register pending-write scoreboard, write-to-read bypass and an optional hardwired zero register. It is the successor of the single-cycle CPU register file for the pipelined core. It sits between decode (read, claim) and writeback (write), and produces the decode-stage stall for read-after-write hazards and scoreboard overflow.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2^ADDR_W
- CNT_W, 2, per-register pending-write counter width; max outstanding writes per register = 2^CNT_W-1
- ZERO_R0, 1, 1: register 0 reads 0, ignores writes and claims, is never busy
- BYPASS, 1, 1: a same-cycle write is visible on the read ports and retires its pending count for the busy check

- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of CLK
- regWr  in  1  write enable (writeback)
- WriteAddr  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- RsAddr, RtAddr  in  ADDR_W  read addresses
- useRs, useRt  in  1  decode actually consumes Rs / Rt this cycle
- claimEn  in  1  decode issues an instruction writing claimAddr
- claimAddr  in  ADDR_W  destination being claimed
- RsData, RtData  out  DATA_W  read data (combinational)
- RsBusy, RtBusy  out  1  read register has uncommitted pending writes
- stall  out  1  decode must hold; the claim is not taken

## Operation
- State: RF[0..2^ADDR_W-1] (DATA_W bits each) and cnt[0..2^ADDR_W-1] (CNT_W bits each).
- Reset (reset==0 at the edge): all RF entries cleared to 0 and all cnt cleared to 0. Reset has priority over regWr and claimEn in that cycle.
- Write: if regWr and not (ZERO_R0 and WriteAddr==0), then RF[WriteAddr] <= WriteData at the edge.
- Write retire (wdec): regWr and a valid address and cnt[WriteAddr]!=0. Retiring decrements the count by 1. A write to a register with cnt==0 (unclaimed write) is legal: data is written and cnt stays 0, with no underflow.
- Read: RsData = 0 if ZERO_R0 and RsAddr==0. Otherwise WriteData if BYPASS and regWr and WriteAddr==RsAddr. Otherwise RF[RsAddr]. RtData follows the same rule.
- Busy: effCnt(a) = cnt[a] - (BYPASS and wdec and WriteAddr==a ? 1 : 0). RsBusy = effCnt(RsAddr)!=0. RtBusy follows the same rule. Both are 0 for r0 when ZERO_R0=1.
- Claim full: claimFull = claimEn and effCnt(claimAddr)==2^CNT_W-1. It is 0 for r0 when ZERO_R0=1.
- stall = (useRs and RsBusy) or (useRt and RtBusy) or claimFull.
- Claim commit (cinc): claimEn and not stall and not (ZERO_R0 and claimAddr==0).
- Counter update per address a: +1 if cinc hits a, -1 if wdec hits a. If both hit a, cnt[a] is unchanged. Increment and decrement on different addresses apply independently.
- The counter never wraps. Saturation is prevented by claimFull.
- All outputs are combinational functions of state and the current inputs. There are no output registers.

## Timing
- Read latency 0 cycles. A written value appears from RF one cycle after the write edge, or in the same cycle via bypass when BYPASS=1.
- With BYPASS=0, a write in cycle N clears busy and updates data at the cycle N+1 read.
- A claim in cycle N makes the register busy from cycle N+1.
- A read of a register claimed in the same cycle does not see the new busy. Claim precedes reads only across cycles, and decode handles its own dependency.
- stall depends combinationally on the writeback port. With BYPASS=1, the writeback that retires the last pending write releases the stall in the same cycle.
- After reset deasserts, all outputs read 0, busy is 0 and stall is 0 (with claimEn=0) in the first cycle.
- Reset mid-operation discards all pending counts. Writebacks arriving after reset are treated as unclaimed writes.

## Test plan
- Reset then read: reset=0 for 1 edge, read r1..r31 -> all 0. RsBusy=RtBusy=stall=0.
- RAW stall: claim r5 (cycle 0). Cycle 1: useRs, RsAddr=5 -> RsBusy=1, stall=1. Cycle 3: regWr r5=0xDEADBEEF -> BYPASS=1: stall=0 and RsData=0xDEADBEEF the same cycle. BYPASS=0: stall drops and data appears in cycle 4.
- Zero register: regWr r0=0x1234 and claim r0 -> RsAddr=0 reads 0, RsBusy=0, cnt[0]=0, stall=0.
- Multiple outstanding writes and full: CNT_W=2, claim r7 three times -> fourth claim gives stall=1 and cnt stays 3. Three writebacks then return cnt to 0, and RtBusy(r7)=0 after the last one.
- Simultaneous claim and write on r9 with cnt=1 -> cnt stays 1 and busy stays 1. Unclaimed write to r10 with cnt=0 -> data 0x55 stored, cnt stays 0.
- Reset mid-operation: cnt[3]=2 and RF[3]=7, assert reset -> cnt[3]=0 and RF[3]=0. A later regWr r3=9 -> RF[3]=9 with no underflow.
